// File: rtl/imem_responder_pkg.sv
// im_pkg: shared FSM states, defaults and constants for the instruction-memory responder
package im_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int CNT_W = 4;
endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/acknowledge bus between the next-PC unit and the instruction memory
interface imem_responder_if;
  logic req;
  logic [31:0] pc;
  logic ack;
  logic [31:0] imout;
  logic fault;
  modport master (output req, pc, input ack, imout, fault);
  modport slave (input req, pc, output ack, imout, fault);
endinterface

// File: rtl/imem_responder_store.sv
// im_store: synchronous-write array with an enabled registered read (old data on same-word write)
module im_store #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic re,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // Only the read register is cleared; array contents survive reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fetch responder with wait states and misaligned/range faults; IM_PARITY_EN adds per-word parity
module imem_responder
  import im_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic clk,
  input  logic rst,
  imem_responder_if.slave bus,
  input  logic ld_we,
  input  logic [AW-1:0] ld_addr,
`ifdef IM_PARITY_EN
  input  logic ld_par_flip,
`endif
  input  logic [31:0] ld_data
);
`ifdef IM_PARITY_EN
  localparam int DW = 33;
`else
  localparam int DW = 32;
`endif
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0] addr_q, addr_nxt, off;
  logic rdy_q, fault_q, take, bad, enter_resp, par_err;
  logic [DW-1:0] rdata, wdata;
  assign take = state == IDLE && bus.req && rdy_q;
  // With zero wait states the read must use pc directly on the accept edge
  assign addr_nxt = take ? bus.pc : addr_q;
  assign off = addr_nxt - BASE_ADDR;
  assign bad = (|addr_nxt[1:0]) || addr_nxt < BASE_ADDR || (off >> 2) >= 32'(DEPTH_WORDS);
  assign enter_resp = state_nxt == RESP && state != RESP;
`ifdef IM_PARITY_EN
  assign wdata = {^ld_data ^ ld_par_flip, ld_data};
`else
  assign wdata = ld_data;
`endif
  im_store #(.DEPTH(DEPTH_WORDS), .WIDTH(DW)) u_store (
    .clk(clk),
    .rst(rst),
    .we(ld_we && 32'(ld_addr) < 32'(DEPTH_WORDS)),
    .waddr(ld_addr),
    .wdata(wdata),
    .re(enter_resp),
    .raddr(off[AW+1:2]),
    .rdata(rdata)
  );
  // rdy_q blocks acceptance on the first edge after reset release
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      rdy_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= 1'b1;
      addr_q <= addr_nxt;
      cnt <= take ? CNT_W'(WAIT_CYCLES) : state == WAIT ? cnt - 1'b1 : cnt;
      if (enter_resp) fault_q <= bad;
    end
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: state_nxt = take ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE;
      WAIT: state_nxt = !bus.req ? IDLE : cnt == 1 ? RESP : WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
`ifdef IM_PARITY_EN
    par_err = ^rdata;
`else
    par_err = 1'b0;
`endif
    bus.ack = state == RESP;
    bus.fault = fault_q | par_err;
    bus.imout = bus.fault ? NOP : rdata[31:0];
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks on two responders (1 and 3 wait states) sharing stimulus
module tb_imem_responder;
  logic clk = 1'b0, rst1 = 1'b0, rst3 = 1'b0;
  logic ld_we = 1'b0;
  logic [9:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
`ifdef IM_PARITY_EN
  logic ld_par_flip = 1'b0;
`endif
  int checks = 0, failures = 0;
  imem_responder_if b1 ();
  imem_responder_if b3 ();
  logic req = 1'b0;
  logic [31:0] pc = '0;
  assign b1.req = req;
  assign b1.pc = pc;
  assign b3.req = req;
  assign b3.pc = pc;
  imem_responder #(.WAIT_CYCLES(1)) d1 (
    .clk(clk), .rst(rst1), .bus(b1), .ld_we(ld_we), .ld_addr(ld_addr),
`ifdef IM_PARITY_EN
    .ld_par_flip(ld_par_flip),
`endif
    .ld_data(ld_data));
  imem_responder #(.WAIT_CYCLES(3)) d3 (
    .clk(clk), .rst(rst3), .bus(b3), .ld_we(ld_we), .ld_addr(ld_addr),
`ifdef IM_PARITY_EN
    .ld_par_flip(ld_par_flip),
`endif
    .ld_data(ld_data));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int w);
    return w == 3 ? b3.ack : b1.ack;
  endfunction

  task automatic load(input logic [9:0] a, input logic [31:0] d, input logic flip);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
`ifdef IM_PARITY_EN
    ld_par_flip = flip;
`endif
    @(negedge clk);
    ld_we = 1'b0;
`ifdef IM_PARITY_EN
    ld_par_flip = 1'b0;
`endif
  endtask

  task automatic fetch(input string tag, input int w, input logic [31:0] a,
                       input int exp_lat, input logic [31:0] exp_im, input logic exp_f);
    int lat;
    repeat (2) @(negedge clk);
    req = 1'b1; pc = a;
    @(posedge clk);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ack_of(w) && lat < 20);
    req = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_im"}, w == 3 ? b3.imout : b1.imout, exp_im);
    chk({tag, "_fault"}, 32'(w == 3 ? b3.fault : b1.fault), 32'(exp_f));
    @(posedge clk); #1;
    chk({tag, "_ackpulse"}, 32'(ack_of(w)), 0);
  endtask

  initial begin
    int n;
    #1;
    chk("rst_ack", 32'(b1.ack), 0);
    chk("rst_fault", 32'(b1.fault), 0);
    chk("rst_im", b1.imout, 0);
    load(10'd0, 32'h2010_0005, 1'b0);
    load(10'd1, 32'h1111_1111, 1'b0);
    load(10'd1023, 32'hDEAD_BEEF, 1'b0);
    // req already high at release: first edge ignored, accept on second
    req = 1'b1; pc = 32'h0000_3000;
    @(negedge clk); rst1 = 1'b1; rst3 = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b1.ack && n < 20);
    req = 1'b0;
    chk("release_lat", 32'(n), 3);
    chk("release_im", b1.imout, 32'h2010_0005);
    fetch("word0", 1, 32'h0000_3000, 1, 32'h2010_0005, 1'b0);
    fetch("misalign", 1, 32'h0000_3002, 1, 32'h0, 1'b1);
    fetch("below", 1, 32'h0000_2FFC, 1, 32'h0, 1'b1);
    fetch("above", 1, 32'h0000_4000, 1, 32'h0, 1'b1);
    fetch("last", 1, 32'h0000_3FFC, 1, 32'hDEAD_BEEF, 1'b0);
    // loader write lands on the edge entering RESP: old word returned
    repeat (2) @(negedge clk);
    req = 1'b1; pc = 32'h0000_3004;
    @(posedge clk); #1;
    ld_we = 1'b1; ld_addr = 10'd1; ld_data = 32'hAAAA_5555;
    @(posedge clk); #1;
    ld_we = 1'b0; req = 1'b0;
    chk("rbw_ack", 32'(b1.ack), 1);
    chk("rbw_old", b1.imout, 32'h1111_1111);
    fetch("rbw_new", 1, 32'h0000_3004, 1, 32'hAAAA_5555, 1'b0);
    // back-to-back throughput with req held high
    repeat (2) @(negedge clk);
    req = 1'b1; pc = 32'h0000_3000;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b1.ack && n < 20);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b1.ack && n < 20);
    req = 1'b0;
    chk("throughput", 32'(n), 3);
    // abort by dropping req in WAIT
    repeat (2) @(negedge clk);
    req = 1'b1; pc = 32'h0000_3000;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    repeat (5) begin @(posedge clk); #1; n += int'(b1.ack); end
    chk("abort_noack", 32'(n), 0);
    // three wait states, then reset in the second WAIT cycle
    fetch("w3", 3, 32'h0000_3000, 3, 32'h2010_0005, 1'b0);
    repeat (2) @(negedge clk);
    req = 1'b1; pc = 32'h0000_3004;
    @(posedge clk);
    @(posedge clk); #2;
    rst3 = 1'b0; #1;
    chk("w3rst_ack", 32'(b3.ack), 0);
    chk("w3rst_fault", 32'(b3.fault), 0);
    chk("w3rst_im", b3.imout, 0);
    req = 1'b0;
    @(negedge clk); rst3 = 1'b1;
    n = 0;
    repeat (8) begin @(posedge clk); #1; n += int'(b3.ack); end
    chk("w3rst_noack", 32'(n), 0);
    fetch("w3_after", 3, 32'h0000_3004, 3, 32'hAAAA_5555, 1'b0);
`ifdef IM_PARITY_EN
    load(10'd2, 32'h1234_5678, 1'b1);
    fetch("par_bad", 1, 32'h0000_3008, 1, 32'h0, 1'b1);
    load(10'd2, 32'h1234_5678, 1'b0);
    fetch("par_ok", 1, 32'h0000_3008, 1, 32'h1234_5678, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder at the memory end of the CPU fetch interface. The next-PC unit presents a fetch address, and this block returns the instruction word with a request/acknowledge handshake and a configurable wait-state count. It also flags misaligned and out-of-range fetches. A side-band loader port fills the array before or between runs.

## Interface
- BASE_ADDR, 32'h0000_3000, byte address of instruction word 0
- DEPTH_WORDS, 1024, number of 32-bit instruction words
- WAIT_CYCLES, 1, wait states between request accept and acknowledge (0..15)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low
- req  input  1  fetch request; held high with pc stable until ack
- pc  input  32  fetch byte address
- ack  output  1  one-cycle pulse; response valid this cycle
- imout  output  32  instruction word; holds value until next ack
- fault  output  1  valid with ack; 1 = misaligned, out of range, or parity error
- ld_we  input  1  loader write strobe
- ld_addr  input  $clog2(DEPTH_WORDS)  loader word index
- ld_data  input  32  loader write data
- ld_par_flip  input  1  present only with IM_PARITY_EN; inverts the stored parity bit on a loader write

## Operation
- States:
  - IDLE: accept request.
  - WAIT: count wait states.
  - RESP: drive response.
- IDLE:
  - req=1 at an edge captures pc into addr_q.
  - Goes to WAIT, loading cnt=WAIT_CYCLES. If WAIT_CYCLES=0, goes directly to RESP.
- WAIT:
  - cnt decrements each cycle. At cnt==1, goes to RESP.
  - If req falls, aborts to IDLE with no ack.
- RESP:
  - ack=1 for exactly one cycle, then IDLE.
  - The array read is sampled on the edge entering RESP.
- Index computation: idx = (addr_q - BASE_ADDR) >> 2, using a 32-bit unsigned subtract.
- Fault conditions:
  - addr_q[1:0] != 0: misaligned.
  - addr_q < BASE_ADDR: out of range.
  - idx >= DEPTH_WORDS: out of range.
- On fault, imout = 32'h0000_0000 (NOP) and fault=1. Otherwise imout = mem[idx] and fault=0.
- Loader:
  - ld_we=1 writes ld_data to mem[ld_addr] at the edge.
  - ld_addr >= DEPTH_WORDS is ignored.
  - Writes are allowed in any state.
- Write and read to the same word on the same edge: the read returns the old data (read-before-write).
- Reset:
  - Outputs: ack=0, fault=0, imout=0.
  - Internal: state=IDLE, cnt=0.
  - Array contents are not reset.
  - Reset asserted in WAIT or RESP abandons the fetch; no ack is ever produced for it.

## Timing
- A request sampled at edge N produces ack high during cycle N+1+WAIT_CYCLES.
- With req held continuously high, fetches are accepted every WAIT_CYCLES+2 cycles, because RESP always returns through IDLE.
- imout and fault change only on the edge entering RESP and are stable through ack.
- Reset assertion is asynchronous; release is synchronous to clk. No request is accepted on the first edge after release.
- pc must not change while req=1 and ack has not yet pulsed. If it does, the value already captured in addr_q is used.

## Configuration
- IM_PARITY_EN defined:
  - Array is 33 bits wide. Bit 32 = ^ld_data, XOR ld_par_flip, written by the loader.
  - On read, a mismatch between recomputed and stored parity gives fault=1 and imout=0.
  - Parity is checked only on in-range, aligned fetches.
- IM_PARITY_EN undefined:
  - Array is 32 bits wide and the ld_par_flip port does not exist.
  - fault reflects alignment and range only.

## Structure
- Package im_pkg holds:
  - State enum (IDLE, WAIT, RESP).
  - Default BASE_ADDR.
  - NOP constant 32'h0000_0000.
  - Wait-counter width (4 bits).
- One sub-module, im_store:
  - Synchronous-write, registered-read array.
  - Parameterised by depth and width (32 or 33).
  - Instantiated once.
- The top level holds the FSM, counter, address/fault logic and output registers.

## Test plan
- Load mem[0]=32'h2010_0005; req with pc=32'h0000_3000, WAIT_CYCLES=1, sampled at edge N -> ack in cycle N+2, imout=32'h2010_0005, fault=0; ack low in the next cycle.
- pc=32'h0000_3002 -> ack, fault=1, imout=0.
- pc=32'h0000_2FFC and pc=32'h0000_4000 (DEPTH_WORDS=1024) -> each acks with fault=1, imout=0.
- Loader writes mem[1]=32'hAAAA_5555 on the same edge that enters RESP for pc=32'h0000_3004 -> imout is the old mem[1]. A repeat fetch returns 32'hAAAA_5555.
- WAIT_CYCLES=3; rst driven low in the second WAIT cycle -> ack, fault and imout go to 0 immediately. No ack after release until a new req is issued.
- With IM_PARITY_EN: load mem[2] with ld_par_flip=1, fetch pc=32'h0000_3008 -> ack, fault=1, imout=0. Reload with ld_par_flip=0 -> fault=0 and the data returns.
